apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//   APB responder peripheral on one PSELx line of the AXI-to-APB bridge.
//   Provides an 8 x 16-bit register file with a programmable number of wait states.
//   Addresses 0-6 are read/write; address 7 is a read-only transfer-count status register.
//   Flags APB sequencing violations made by the requester.
// PARAMETERS
//   WAIT_CYCLES  1   wait states inserted per transfer before PREADY (legal range 0..15)
//   RST_VAL      0   reset value of registers 0-6 (16 bits)
// PORTS
//   clk        in   1   system clock; all state changes on the rising edge
//   res        in   1   asynchronous reset, active-high
//   PSEL       in   1   slave select from the bridge (PSELx)
//   PENABLE    in   1   APB access-phase strobe
//   PWRITE     in   1   1 = write, 0 = read
//   PADDR      in   3   register index
//   PWDATA     in   16  write data
//   PRDATA     out  16  read data; valid only while PREADY=1 on a read
//   PREADY     out  1   transfer completes in the cycle where PREADY=1 and PENABLE=1
//   wr_count   out  8   number of committed writes, modulo 256
//   rd_count   out  8   number of completed reads, modulo 256
//   proto_err  out  1   one-cycle pulse on an APB sequencing violation
// BEHAVIOUR
//   Reset (async, res=1):
//     - state=IDLE; PREADY=0, PRDATA=0, proto_err=0.
//     - wr_count=0, rd_count=0, registers 0-6 = RST_VAL.
//     - Takes effect immediately, including mid-transfer. An in-flight write is dropped.
//   State machine (all outputs registered):
//     IDLE:
//       - PSEL=1, PENABLE=0 (setup phase): latch PADDR, PWRITE, PWDATA.
//       - Then go to ACCESS if WAIT_CYCLES=0; otherwise go to WAIT with cnt=WAIT_CYCLES-1.
//       - PSEL=1, PENABLE=1 (access without setup): pulse proto_err, stay in IDLE, no side effects.
//     WAIT:
//       - PREADY=0.
//       - PSEL=1, PENABLE=1: if cnt=0 go to ACCESS, else cnt <= cnt-1.
//       - Otherwise: pulse proto_err, go to IDLE, abort with no write.
//     ACCESS:
//       - PREADY=1.
//       - PSEL=1, PENABLE=1: transfer completes at this edge and the FSM returns to IDLE.
//         * Write, addr 0-6: reg <= latched wdata; wr_count++.
//         * Write, addr 7: ignored, no count change, still completes normally.
//         * Read: rd_count++.
//       - Otherwise: pulse proto_err, go to IDLE, no write, no count change.
//   Timing:
//     - PREADY rises in access cycle WAIT_CYCLES+1, counted from the first PENABLE=1 cycle.
//     - A full transfer is 1 setup cycle + WAIT_CYCLES + 1 cycles.
//     - Back-to-back transfers are legal: the next setup cycle is sampled in IDLE on the cycle after ACCESS.
//   PRDATA:
//     - Loaded on entry to ACCESS for a read: reg[addr], or {wr_count, rd_count} for addr 7.
//     - The addr 7 value is the pre-increment value.
//     - 0 in every other cycle.
//   Latching: PADDR, PWRITE and PWDATA are used only as latched in setup.
//     Changes during WAIT or ACCESS are ignored.
//   Counters wrap 255 -> 0 with no flag.
//   proto_err is high for exactly one cycle per violation.
// TESTING
//   1. Reset, then read addr 3 -> PRDATA=16'h0000, PREADY high in the 2nd PENABLE cycle, rd_count=1.
//   2. Write addr 1..4 = 16'hFFFF, 16'h1111, 16'h2222, 16'h3333, then read 1..4
//      -> same data returned, wr_count=4, rd_count=4.
//   3. Write 16'h1234 to addr 7, then read addr 7 -> write completes,
//      read returns {8'd0, 8'd0} after reset, and counts are unchanged by the addr 7 write.
//   4. Drop PSEL during WAIT on a write of 16'hABCD to addr 2 -> proto_err pulses 1 cycle,
//      reg2 unchanged, wr_count unchanged.
//   5. Assert res during ACCESS of a write -> PREADY=0 immediately,
//      write not committed, all counts 0.
//   6. WAIT_CYCLES=0 build; 256 back-to-back writes -> PREADY high in the 1st PENABLE cycle
//      every time, wr_count wraps to 0.

Source files
------------

// File: rtl/apb_reg_if.sv
// APB bus signals between the AXI-to-APB bridge (master) and one register responder (slave).
interface apb_reg_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [2:0]  PADDR;
    logic [15:0] PWDATA;
    logic [15:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB responder: 7 read/write 16-bit registers plus a read-only {wr_count, rd_count} status word
// at index 7, programmable wait states and detection of requester sequencing violations.
module apb_reg_slave #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] RST_VAL     = 16'h0000
) (
    input  logic            clk,
    input  logic            res,
    apb_reg_if.slave        bus,
    output logic [7:0]      wr_count,
    output logic [7:0]      rd_count,
    output logic            proto_err
);

    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [2:0] STAT_ADDR = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pready_q, pready_d;
    logic [15:0] prdata_q, prdata_d;
    logic        perr_d;
    logic        latch, wr_commit, rd_commit;

    logic [2:0]  addr_q;
    logic        write_q;
    logic [15:0] wdata_q;
    logic [2:0]  cur_addr;
    logic        cur_write;
    logic [15:0] regs [0:6];

    wire access_ph = bus.PSEL && bus.PENABLE;

    // With no wait states ACCESS is entered straight from the setup cycle, before the latch holds it.
    assign cur_addr  = (state_q == S_IDLE) ? bus.PADDR  : addr_q;
    assign cur_write = (state_q == S_IDLE) ? bus.PWRITE : write_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        prdata_d  = 16'h0000;
        perr_d    = 1'b0;
        latch     = 1'b0;
        wr_commit = 1'b0;
        rd_commit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else if (access_ph) begin
                    perr_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (access_ph) begin
                    if (cnt_q == 4'd0) state_d = S_ACCESS;
                    else               cnt_d   = cnt_q - 4'd1;
                end else begin
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                if (access_ph) begin
                    if (write_q) wr_commit = (addr_q != STAT_ADDR);
                    else         rd_commit = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status word is captured before this read's own increment.
        if (state_d == S_ACCESS) begin
            pready_d = 1'b1;
            if (!cur_write) begin
                if (cur_addr == STAT_ADDR) prdata_d = {wr_count, rd_count};
                else                       prdata_d = regs[cur_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            prdata_q  <= 16'h0000;
            proto_err <= 1'b0;
            wr_count  <= 8'd0;
            rd_count  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            proto_err <= perr_d;
            if (wr_commit) wr_count <= wr_count + 8'd1;
            if (rd_commit) rd_count <= rd_count + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 7; i++) regs[i] <= RST_VAL;
        end else if (wr_commit) begin
            regs[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            addr_q  <= bus.PADDR;
            write_q <= bus.PWRITE;
            wdata_q <= bus.PWDATA;
        end
    end

    assign bus.PREADY = pready_q;
    assign bus.PRDATA = prdata_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed and randomized bench for apb_reg_slave with one and zero wait states,
// checked against an array model of the register file and transfer counters.
module tb_apb_reg_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res1, res0;
    logic [7:0] wc1, rc1, wc0, rc0;
    logic pe1, pe0;

    apb_reg_if b1();
    apb_reg_if b0();

    apb_reg_slave #(.WAIT_CYCLES(1), .RST_VAL(16'h0000)) dut1 (
        .clk(clk), .res(res1), .bus(b1.slave),
        .wr_count(wc1), .rd_count(rc1), .proto_err(pe1)
    );

    apb_reg_slave #(.WAIT_CYCLES(0), .RST_VAL(16'h5A5A)) dut0 (
        .clk(clk), .res(res0), .bus(b0.slave),
        .wr_count(wc0), .rd_count(rc0), .proto_err(pe0)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and counters per DUT (index 1 = one wait state, 0 = none).
    logic [15:0] mem [2][8];
    logic [7:0]  mw [2];
    logic [7:0]  mr [2];
    logic [15:0] rstv [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int w);
        for (int i = 0; i < 8; i++) mem[w][i] = rstv[w];
        mw[w] = 8'd0;
        mr[w] = 8'd0;
    endtask

    task automatic drive(input int w, input logic sel, input logic en, input logic wr,
                         input logic [2:0] a, input logic [15:0] d);
        if (w == 1) begin
            b1.PSEL = sel; b1.PENABLE = en; b1.PWRITE = wr; b1.PADDR = a; b1.PWDATA = d;
        end else begin
            b0.PSEL = sel; b0.PENABLE = en; b0.PWRITE = wr; b0.PADDR = a; b0.PWDATA = d;
        end
    endtask

    function automatic logic [31:0] rdy(input int w);
        return {31'd0, (w == 1) ? b1.PREADY : b0.PREADY};
    endfunction
    function automatic logic [31:0] prd(input int w);
        return {16'd0, (w == 1) ? b1.PRDATA : b0.PRDATA};
    endfunction
    function automatic logic [31:0] perr(input int w);
        return {31'd0, (w == 1) ? pe1 : pe0};
    endfunction
    function automatic logic [31:0] wcnt(input int w);
        return {24'd0, (w == 1) ? wc1 : wc0};
    endfunction
    function automatic logic [31:0] rcnt(input int w);
        return {24'd0, (w == 1) ? rc1 : rc0};
    endfunction

    task automatic idle(input int w);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic chk_counts(input int w);
        check("wr_count", wcnt(w), {24'd0, mw[w]});
        check("rd_count", rcnt(w), {24'd0, mr[w]});
    endtask

    // One complete transfer; address/data are scrambled after setup since only latched values count.
    task automatic xfer(input int w, input logic wr, input logic [2:0] a, input logic [15:0] d);
        int n;
        logic [31:0] r;
        logic [31:0] exp;
        @(negedge clk);
        drive(w, 1'b1, 1'b0, wr, a, d);
        @(negedge clk);
        r = $urandom;
        drive(w, 1'b1, 1'b1, wr, r[2:0], r[31:16]);
        n = 1;
        while (rdy(w) == 32'd0 && n < 20) begin
            check("prdata_idle", prd(w), 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", n, (w == 1) ? 32'd2 : 32'd1);
        check("perr_clean", perr(w), 32'd0);
        if (rdy(w) == 32'd1) begin
            if (!wr) begin
                exp = (a == 3'd7) ? {16'd0, mw[w], mr[w]} : {16'd0, mem[w][a]};
                check("rdata", prd(w), exp);
                mr[w] = mr[w] + 8'd1;
            end else if (a != 3'd7) begin
                mem[w][a] = d;
                mw[w] = mw[w] + 8'd1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [2:0]  a;
        rstv[1] = 16'h0000;
        rstv[0] = 16'h5A5A;
        model_reset(1);
        model_reset(0);
        res1 = 1'b1;
        res0 = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        drive(0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_pready", rdy(1), 32'd0);
        check("rst_prdata", prd(1), 32'd0);
        check("rst_perr", perr(1), 32'd0);
        chk_counts(1);
        res1 = 1'b0;
        res0 = 1'b0;

        // Status register write is ignored; status read right after reset is {0,0}
        xfer(1, 1'b1, 3'd7, 16'h1234);
        xfer(1, 1'b0, 3'd7, 16'h0000);
        idle(1);
        chk_counts(1);

        xfer(1, 1'b0, 3'd3, 16'h0000);
        idle(1);
        chk_counts(1);

        xfer(1, 1'b1, 3'd1, 16'hFFFF);
        xfer(1, 1'b1, 3'd2, 16'h1111);
        xfer(1, 1'b1, 3'd3, 16'h2222);
        xfer(1, 1'b1, 3'd4, 16'h3333);
        for (int i = 1; i <= 4; i++) begin
            a = 3'(i);
            xfer(1, 1'b0, a, 16'h0000);
        end
        idle(1);
        chk_counts(1);

        // PSEL dropped during WAIT: abort with one-cycle error pulse
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 3'd2, 16'hABCD);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b1, 3'd2, 16'hABCD);
        @(negedge clk);
        check("abort_perr", perr(1), 32'd1);
        @(negedge clk);
        check("abort_perr_len", perr(1), 32'd0);
        chk_counts(1);
        xfer(1, 1'b0, 3'd2, 16'h0000);

        // Access phase without setup
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 3'd0, 16'hDEAD);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        check("nosetup_perr", perr(1), 32'd1);
        @(negedge clk);
        check("nosetup_perr_len", perr(1), 32'd0);
        chk_counts(1);
        xfer(1, 1'b0, 3'd0, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            xfer(1, r[0], r[3:1], r[31:16]);
            if (r[4]) idle(1);
        end
        idle(1);
        chk_counts(1);

        // Reset asserted in ACCESS of a write
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 3'd5, 16'hBEEF);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 3'd5, 16'hBEEF);
        @(negedge clk);
        check("pre_rst_pready", rdy(1), 32'd1);
        #1 res1 = 1'b1;
        #1;
        check("midrst_pready", rdy(1), 32'd0);
        model_reset(1);
        chk_counts(1);
        @(negedge clk);
        res1 = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        xfer(1, 1'b0, 3'd5, 16'h0000);
        idle(1);

        // Zero wait states: reset value, then 256 back-to-back writes wrap wr_count
        xfer(0, 1'b0, 3'd6, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            a = (r[2:0] == 3'd7) ? 3'd0 : r[2:0];
            xfer(0, 1'b1, a, r[31:16]);
        end
        idle(0);
        check("wr_wrap", wcnt(0), 32'd0);
        chk_counts(0);
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            xfer(0, 1'b0, a, 16'h0000);
        end
        idle(0);
        chk_counts(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
